// File: rtl/snowbro2_pcm_pkg.sv
// Shared types and sizing for the snowbro2 ADPCM sample-ROM server.
package snowbro2_pcm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BEAT0,
    BEAT1
  } state_t;

  localparam int LINE_BYTES = 4;
  localparam int BEATS      = 2;
  localparam int BEAT_BYTES = LINE_BYTES / BEATS;
  localparam int SDW        = 22;

endpackage

// File: rtl/snowbro2_pcm_line.sv
// Single 4-byte line buffer with tag/valid, hit compare and byte select.
module snowbro2_pcm_line
  import snowbro2_pcm_pkg::*;
#(
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr_lo,
  input  logic          wr_hi,
  input  logic [15:0]   wr_data,
  input  logic [AW-3:0] fill_tag,
  input  logic          fill_valid,
  input  logic          invalidate,
  output logic          hit,
  output logic [7:0]    rd_byte
);

  logic [LINE_BYTES-1:0][7:0] line_q;
  logic [AW-3:0]              tag_q;
  logic                       valid_q;

  // Tag and valid only change on the final beat, so a half-filled line never hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_lo) begin
        line_q[0] <= wr_data[7:0];
        line_q[1] <= wr_data[15:8];
      end
      if (wr_hi) begin
        line_q[BEAT_BYTES]   <= wr_data[7:0];
        line_q[BEAT_BYTES+1] <= wr_data[15:8];
        tag_q                <= fill_tag;
        valid_q              <= fill_valid;
      end else if (invalidate) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign hit     = cs & valid_q & (tag_q == addr[AW-1:2]);
  assign rd_byte = line_q[addr[1:0]];

endmodule

// File: rtl/snowbro2_pcm_rom_server.sv
// Serves PCM byte reads from a one-line buffer, refilling it from SDRAM in 2-beat bursts.
module snowbro2_pcm_rom_server
  import snowbro2_pcm_pkg::*;
#(
  parameter int             AW     = 20,
  parameter logic [SDW-1:0] OFFSET = 22'h000000
) (
  input  logic           CLK96,
  input  logic           RESET96_N,
  input  logic           PCM_CS,
  input  logic [AW-1:0]  PCM_ADDR,
  output logic [7:0]     PCM_DOUT,
  output logic           PCM_OK,
  input  logic           FLUSH,
  output logic           SDRAM_REQ,
  output logic [SDW-1:0] SDRAM_ADDR,
  input  logic           SDRAM_ACK,
  input  logic           SDRAM_DST,
  input  logic [15:0]    SDRAM_DATA
);

  state_t         state_q, state_d;
  logic           hit;
  logic [7:0]     rd_byte;
  logic           start_fetch;
  logic           wr_lo;
  logic           wr_hi;
  logic           invalidate;
  logic           fill_valid;
  logic           drop_q;
  logic [AW-3:0]  fetch_tag;
  logic [SDW-1:0] word_addr;

  assign word_addr = OFFSET + {{(SDW-AW+1){1'b0}}, PCM_ADDR[AW-1:2], 1'b0};

  snowbro2_pcm_line #(.AW(AW)) u_line (
    .clk        (CLK96),
    .rst_n      (RESET96_N),
    .cs         (PCM_CS),
    .addr       (PCM_ADDR),
    .wr_lo      (wr_lo),
    .wr_hi      (wr_hi),
    .wr_data    (SDRAM_DATA),
    .fill_tag   (fetch_tag),
    .fill_valid (fill_valid),
    .invalidate (invalidate),
    .hit        (hit),
    .rd_byte    (rd_byte)
  );

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_fetch = 1'b0;
    wr_lo       = 1'b0;
    wr_hi       = 1'b0;
    case (state_q)
      IDLE: begin
        if (PCM_CS && !hit) begin
          start_fetch = 1'b1;
          state_d     = REQ;
        end
      end
      REQ:   if (SDRAM_ACK) state_d = BEAT0;
      BEAT0: begin
        if (SDRAM_DST) begin
          wr_lo   = 1'b1;
          state_d = BEAT1;
        end
      end
      BEAT1: begin
        if (SDRAM_DST) begin
          wr_hi   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    invalidate = (state_q == IDLE) && (FLUSH || start_fetch);
    // A flush landing on the final beat must also keep the line invalid.
    fill_valid = !(drop_q || FLUSH);
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      PCM_OK     <= 1'b0;
      PCM_DOUT   <= '0;
      SDRAM_REQ  <= 1'b0;
      SDRAM_ADDR <= '0;
      fetch_tag  <= '0;
      drop_q     <= 1'b0;
    end else begin
      PCM_OK   <= hit;
      PCM_DOUT <= rd_byte;
      if (start_fetch) begin
        SDRAM_REQ  <= 1'b1;
        SDRAM_ADDR <= word_addr;
        fetch_tag  <= PCM_ADDR[AW-1:2];
      end else if (state_q == REQ && SDRAM_ACK) begin
        SDRAM_REQ <= 1'b0;
      end
      if (wr_hi)                         drop_q <= 1'b0;
      else if (FLUSH && state_q != IDLE) drop_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snowbro2_pcm_rom_server.sv
// Directed bench for the PCM ROM server; three instances with different OFFSETs run in lockstep.
module tb_snowbro2_pcm_rom_server;

  localparam logic [21:0] OFF0 = 22'h000000;
  localparam logic [21:0] OFF1 = 22'h100000;
  localparam logic [21:0] OFFW = 22'h3FFFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic [19:0] addr;
  logic        flush;
  logic        ack;
  logic        dst;
  logic [15:0] sdata;

  logic [2:0]  ok_v;
  logic [2:0]  req_v;
  logic [7:0]  dout_v [3];
  logic [21:0] saddr_v [3];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        cs;
    logic [19:0] addr;
    logic        flush;
    logic        ack;
    logic        dst;
    logic [15:0] data;
    logic        ok;
    logic [7:0]  dout;
    logic        req;
    logic [21:0] word;
    logic        chk_dout;
    logic        chk_addr;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  snowbro2_pcm_rom_server #(.AW(20), .OFFSET(OFF0)) dut0 (
    .CLK96(clk), .RESET96_N(rst_n), .PCM_CS(cs), .PCM_ADDR(addr),
    .PCM_DOUT(dout_v[0]), .PCM_OK(ok_v[0]), .FLUSH(flush),
    .SDRAM_REQ(req_v[0]), .SDRAM_ADDR(saddr_v[0]), .SDRAM_ACK(ack),
    .SDRAM_DST(dst), .SDRAM_DATA(sdata)
  );

  snowbro2_pcm_rom_server #(.AW(20), .OFFSET(OFF1)) dut1 (
    .CLK96(clk), .RESET96_N(rst_n), .PCM_CS(cs), .PCM_ADDR(addr),
    .PCM_DOUT(dout_v[1]), .PCM_OK(ok_v[1]), .FLUSH(flush),
    .SDRAM_REQ(req_v[1]), .SDRAM_ADDR(saddr_v[1]), .SDRAM_ACK(ack),
    .SDRAM_DST(dst), .SDRAM_DATA(sdata)
  );

  snowbro2_pcm_rom_server #(.AW(20), .OFFSET(OFFW)) dutw (
    .CLK96(clk), .RESET96_N(rst_n), .PCM_CS(cs), .PCM_ADDR(addr),
    .PCM_DOUT(dout_v[2]), .PCM_OK(ok_v[2]), .FLUSH(flush),
    .SDRAM_REQ(req_v[2]), .SDRAM_ADDR(saddr_v[2]), .SDRAM_ACK(ack),
    .SDRAM_DST(dst), .SDRAM_DATA(sdata)
  );

  function automatic logic [21:0] off_of(input int i);
    case (i)
      0:       return OFF0;
      1:       return OFF1;
      default: return OFFW;
    endcase
  endfunction

  function automatic vec_t mk(input logic c, input logic [19:0] a, input logic f,
                              input logic k, input logic d, input logic [15:0] dat,
                              input logic ok, input logic [7:0] dout, input logic rq,
                              input logic [21:0] w);
    vec_t v;
    v.cs = c;  v.addr = a;  v.flush = f;  v.ack = k;  v.dst = d;  v.data = dat;
    v.ok = ok; v.dout = dout; v.req = rq; v.word = w;
    v.chk_dout = ok;
    v.chk_addr = 1'b1;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    cs    = v.cs;
    addr  = v.addr;
    flush = v.flush;
    ack   = v.ack;
    dst   = v.dst;
    sdata = v.data;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input int idx, input vec_t v);
    for (int i = 0; i < 3; i++) begin
      automatic logic [21:0] e = off_of(i) + v.word;
      cmp($sformatf("%s%0d.ok.u%0d", tag, idx, i), 32'(ok_v[i]), 32'(v.ok));
      cmp($sformatf("%s%0d.req.u%0d", tag, idx, i), 32'(req_v[i]), 32'(v.req));
      if (v.chk_addr)
        cmp($sformatf("%s%0d.saddr.u%0d", tag, idx, i), 32'(saddr_v[i]), 32'(e));
      else
        cmp($sformatf("%s%0d.saddr.u%0d", tag, idx, i), 32'(saddr_v[i]), 32'h0);
      if (v.chk_dout)
        cmp($sformatf("%s%0d.dout.u%0d", tag, idx, i), 32'(dout_v[i]), 32'(v.dout));
    end
  endtask

  task automatic step(input string tag, input int idx, input vec_t v);
    apply_stimulus(v);
    check_output(tag, idx, v);
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("%s.ok.u%0d", tag, i), 32'(ok_v[i]), 32'h0);
      cmp($sformatf("%s.req.u%0d", tag, i), 32'(req_v[i]), 32'h0);
      cmp($sformatf("%s.dout.u%0d", tag, i), 32'(dout_v[i]), 32'h0);
      cmp($sformatf("%s.saddr.u%0d", tag, i), 32'(saddr_v[i]), 32'h0);
    end
  endtask

  initial begin
    automatic vec_t v;

    // Miss after reset, hits within the line, then a line crossing.
    //                cs  addr      fl ak ds data      ok dout   rq word
    tbl.push_back(mk(1, 20'h00005, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h2));
    tbl.push_back(mk(1, 20'h00005, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h2));
    tbl.push_back(mk(1, 20'h00005, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h2));
    tbl.push_back(mk(1, 20'h00005, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 22'h2));
    tbl.push_back(mk(1, 20'h00005, 0, 0, 1, 16'hBBAA, 0, 8'h00, 0, 22'h2));
    tbl.push_back(mk(1, 20'h00005, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 22'h2));
    tbl.push_back(mk(1, 20'h00005, 0, 0, 1, 16'hDDCC, 0, 8'h00, 0, 22'h2));
    tbl.push_back(mk(1, 20'h00005, 0, 0, 0, 16'h0000, 1, 8'hBB, 0, 22'h2));
    tbl.push_back(mk(1, 20'h00004, 0, 0, 0, 16'h0000, 1, 8'hAA, 0, 22'h2));
    tbl.push_back(mk(1, 20'h00006, 0, 0, 0, 16'h0000, 1, 8'hCC, 0, 22'h2));
    tbl.push_back(mk(1, 20'h00007, 0, 0, 0, 16'h0000, 1, 8'hDD, 0, 22'h2));
    tbl.push_back(mk(1, 20'h00008, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h4));
    tbl.push_back(mk(1, 20'h00008, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 22'h4));
    tbl.push_back(mk(1, 20'h00008, 0, 0, 1, 16'h2211, 0, 8'h00, 0, 22'h4));
    tbl.push_back(mk(1, 20'h00008, 0, 0, 1, 16'h4433, 0, 8'h00, 0, 22'h4));
    tbl.push_back(mk(1, 20'h00008, 0, 0, 0, 16'h0000, 1, 8'h11, 0, 22'h4));
    tbl.push_back(mk(1, 20'h0000B, 0, 0, 0, 16'h0000, 1, 8'h44, 0, 22'h4));
    tbl.push_back(mk(0, 20'h0000B, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 22'h4));
    tbl.push_back(mk(0, 20'h0000B, 0, 0, 0, 16'h0000, 0, 8'h00, 0, 22'h4));

    rst_n = 1'b0;
    cs = 1'b0; addr = '0; flush = 1'b0; ack = 1'b0; dst = 1'b0; sdata = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) step("tbl", i, tbl[i]);

    // Flush during BEAT0: fill completes but stays invalid, then a refetch succeeds.
    step("fl", 0,  mk(1, 20'h0000C, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h6));
    step("fl", 1,  mk(1, 20'h0000C, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 22'h6));
    step("fl", 2,  mk(1, 20'h0000C, 1, 0, 0, 16'h0000, 0, 8'h00, 0, 22'h6));
    step("fl", 3,  mk(1, 20'h0000C, 0, 0, 1, 16'h6655, 0, 8'h00, 0, 22'h6));
    step("fl", 4,  mk(1, 20'h0000C, 0, 0, 1, 16'h8877, 0, 8'h00, 0, 22'h6));
    step("fl", 5,  mk(1, 20'h0000C, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h6));
    step("fl", 6,  mk(1, 20'h0000C, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 22'h6));
    step("fl", 7,  mk(1, 20'h0000C, 0, 0, 1, 16'h6655, 0, 8'h00, 0, 22'h6));
    step("fl", 8,  mk(1, 20'h0000C, 0, 0, 1, 16'h8877, 0, 8'h00, 0, 22'h6));
    step("fl", 9,  mk(1, 20'h0000C, 0, 0, 0, 16'h0000, 1, 8'h55, 0, 22'h6));
    step("fl", 10, mk(1, 20'h0000F, 0, 0, 0, 16'h0000, 1, 8'h88, 0, 22'h6));

    // Flush in IDLE on a hit, then a flush coincident with the final beat.
    step("fi", 0, mk(1, 20'h0000F, 1, 0, 0, 16'h0000, 1, 8'h88, 0, 22'h6));
    step("fi", 1, mk(1, 20'h0000F, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h6));
    step("fi", 2, mk(1, 20'h0000F, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 22'h6));
    step("fi", 3, mk(1, 20'h0000F, 0, 0, 1, 16'h6655, 0, 8'h00, 0, 22'h6));
    step("fi", 4, mk(1, 20'h0000F, 1, 0, 1, 16'h8877, 0, 8'h00, 0, 22'h6));
    step("fi", 5, mk(1, 20'h0000F, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h6));
    step("fi", 6, mk(1, 20'h0000F, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 22'h6));
    step("fi", 7, mk(1, 20'h0000F, 0, 0, 1, 16'h6655, 0, 8'h00, 0, 22'h6));
    step("fi", 8, mk(1, 20'h0000F, 0, 0, 1, 16'h8877, 0, 8'h00, 0, 22'h6));
    step("fi", 9, mk(1, 20'h0000F, 0, 0, 0, 16'h0000, 1, 8'h88, 0, 22'h6));

    // Address change while in REQ; second fetch wraps the 22-bit sum on dutw.
    step("ac", 0,  mk(1, 20'h00005, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h2));
    step("ac", 1,  mk(1, 20'h00010, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h2));
    step("ac", 2,  mk(1, 20'h00010, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 22'h2));
    step("ac", 3,  mk(1, 20'h00010, 0, 0, 1, 16'hBBAA, 0, 8'h00, 0, 22'h2));
    step("ac", 4,  mk(1, 20'h00010, 0, 0, 1, 16'hDDCC, 0, 8'h00, 0, 22'h2));
    step("ac", 5,  mk(1, 20'h00010, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h8));
    step("ac", 6,  mk(1, 20'h00010, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 22'h8));
    step("ac", 7,  mk(1, 20'h00010, 0, 0, 1, 16'hA1A0, 0, 8'h00, 0, 22'h8));
    step("ac", 8,  mk(1, 20'h00010, 0, 0, 1, 16'hA3A2, 0, 8'h00, 0, 22'h8));
    step("ac", 9,  mk(1, 20'h00010, 0, 0, 0, 16'h0000, 1, 8'hA0, 0, 22'h8));
    step("ac", 10, mk(1, 20'h00012, 0, 0, 0, 16'h0000, 1, 8'hA2, 0, 22'h8));

    // Reset pulse while in BEAT1, stray beat after release, then a clean refetch.
    step("rs", 0, mk(1, 20'h00005, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h2));
    step("rs", 1, mk(1, 20'h00005, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 22'h2));
    step("rs", 2, mk(1, 20'h00005, 0, 0, 1, 16'hBBAA, 0, 8'h00, 0, 22'h2));
    cs = 1'b0; ack = 1'b0; dst = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    v = mk(0, 20'h00005, 0, 0, 1, 16'hFFFF, 0, 8'h00, 0, 22'h0);
    v.chk_addr = 1'b0;
    v.chk_dout = 1'b1;
    step("rs", 3, v);
    step("rs", 4, mk(1, 20'h00005, 0, 0, 0, 16'h0000, 0, 8'h00, 1, 22'h2));
    step("rs", 5, mk(1, 20'h00005, 0, 1, 0, 16'h0000, 0, 8'h00, 0, 22'h2));
    step("rs", 6, mk(1, 20'h00005, 0, 0, 1, 16'h3130, 0, 8'h00, 0, 22'h2));
    step("rs", 7, mk(1, 20'h00005, 0, 0, 1, 16'h3332, 0, 8'h00, 0, 22'h2));
    step("rs", 8, mk(1, 20'h00005, 0, 0, 0, 16'h0000, 1, 8'h31, 0, 22'h2));
    step("rs", 9, mk(1, 20'h00006, 0, 0, 0, 16'h0000, 1, 8'h32, 0, 22'h2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
